f_pc_unit: RTL and testbench

- Fetch-stage program counter for the 5-stage MIPS pipeline, directly upstream of the F/D pipeline register.
- Holds PC_F and drives the instruction-memory address i_inst_addr.
- Supplies PC4_F to the F/D register.
- Computes the next PC from the control-flow instruction resolved in D: branch, j/jal, jr/jalr. One architectural delay slot.
- Freezes under exactly the same condition as the F/D register, so fetch and D never disagree.

---
 rtl/f_pc_unit_pkg.sv | 19 +
 rtl/f_pc_unit_npc_calc.sv | 31 +++
 rtl/f_pc_unit.sv | 67 ++++++
 tb/tb_f_pc_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/f_pc_unit_pkg.sv
// Pipeline definitions shared by the D-stage decoder and the fetch PC unit.
package f_pc_unit_pkg;

   localparam int unsigned NPC_SEL_W = 2;

   // Next-PC source for the control-flow instruction currently in D.
   localparam logic [NPC_SEL_W-1:0] NPC_PC4 = 2'd0;
   localparam logic [NPC_SEL_W-1:0] NPC_BR  = 2'd1;
   localparam logic [NPC_SEL_W-1:0] NPC_J   = 2'd2;
   localparam logic [NPC_SEL_W-1:0] NPC_JR  = 2'd3;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   // Branch offset: sign-extended word offset converted to a byte offset.
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/f_pc_unit_npc_calc.sv
// Combinational next-PC selection for the fetch stage.
module f_pc_unit_npc_calc
   import f_pc_unit_pkg::*;
(
   input  logic [31:0]          pc_f_i,
   input  logic [31:0]          pc4_d_i,
   input  logic [NPC_SEL_W-1:0] npc_sel_d_i,
   input  logic                 br_taken_d_i,
   input  logic [15:0]          imm16_d_i,
   input  logic [25:0]          imm26_d_i,
   input  logic [31:0]          rs_data_d_i,
   output logic [31:0]          npc_o
);

   logic [31:0] pc4_f;

   assign pc4_f = pc_f_i + 32'd4;

   // Select the next fetch address; a not-taken branch falls through past the delay slot in F.
   always_comb begin
      npc_o = pc4_f;
      unique case (npc_sel_d_i)
         NPC_PC4: npc_o = pc4_f;
         NPC_BR:  npc_o = br_taken_d_i ? (pc4_d_i + br_offset(imm16_d_i)) : pc4_f;
         NPC_J:   npc_o = {pc4_d_i[31:28], imm26_d_i, 2'b00};
         NPC_JR:  npc_o = rs_data_d_i;
         default: npc_o = pc4_f;
      endcase
   end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage program counter: PC register, freeze enable and reset.
module f_pc_unit
   import f_pc_unit_pkg::*;
#(
   parameter int unsigned         ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = RESET_PC_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 BUSY,
   input  logic                 start,
   input  logic [NPC_SEL_W-1:0] npc_sel_D,
   input  logic                 br_taken_D,
   input  logic [15:0]          imm16_D,
   input  logic [25:0]          imm26_D,
   input  logic [ADDR_W-1:0]    rs_data_D,
   input  logic [ADDR_W-1:0]    PC4_D,
   output logic [ADDR_W-1:0]    i_inst_addr,
   output logic [ADDR_W-1:0]    PC_F,
   output logic [ADDR_W-1:0]    PC4_F,
   output logic                 misalign_F
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] npc;
   logic              en_f;

   // Must stay bit-identical to the F/D register enable so F and D freeze together.
   assign en_f = ~(stall | BUSY | start);

   f_pc_unit_npc_calc u_npc_calc (
      .pc_f_i       (pc_q),
      .pc4_d_i      (PC4_D),
      .npc_sel_d_i  (npc_sel_D),
      .br_taken_d_i (br_taken_D),
      .imm16_d_i    (imm16_D),
      .imm26_d_i    (imm26_D),
      .rs_data_d_i  (rs_data_D),
      .npc_o        (npc)
   );

   // Advance to the selected next PC unless the pipeline front end is frozen.
   always_comb begin
      pc_d = pc_q;
      if (en_f) begin
         pc_d = npc;
      end
   end

   // PC register; reset wins over any freeze condition.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Outputs depend on the PC register only.
   assign PC_F        = pc_q;
   assign i_inst_addr = pc_q;
   assign PC4_F       = pc_q + ADDR_W'(4);
   assign misalign_F  = |pc_q[1:0];

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed plan steps followed by randomized traffic.
module tb_f_pc_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        BUSY = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  npc_sel_D = 2'd0;
   logic        br_taken_D = 1'b0;
   logic [15:0] imm16_D = '0;
   logic [25:0] imm26_D = '0;
   logic [31:0] rs_data_D = '0;
   logic [31:0] PC4_D = '0;
   logic [31:0] i_inst_addr;
   logic [31:0] PC_F;
   logic [31:0] PC4_F;
   logic        misalign_F;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_pc = 32'h0000_3000;

   always #5 clk = ~clk;

   f_pc_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .BUSY        (BUSY),
      .start       (start),
      .npc_sel_D   (npc_sel_D),
      .br_taken_D  (br_taken_D),
      .imm16_D     (imm16_D),
      .imm26_D     (imm26_D),
      .rs_data_D   (rs_data_D),
      .PC4_D       (PC4_D),
      .i_inst_addr (i_inst_addr),
      .PC_F        (PC_F),
      .PC4_F       (PC4_F),
      .misalign_F  (misalign_F)
   );

   // Architectural next-PC rule, written from the ISA description.
   function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] sel,
                                           input logic tk, input logic [15:0] i16,
                                           input logic [25:0] i26, input logic [31:0] rs,
                                           input logic [31:0] pc4d);
      int signed   off;
      logic [31:0] r;
      off = int'($signed(i16)) * 4;
      case (sel)
         2'd1:    r = tk ? (pc4d + 32'(off)) : (pc + 32'd4);
         2'd2:    r = (pc4d & 32'hF000_0000) | (32'(i26) * 4);
         2'd3:    r = rs;
         default: r = pc + 32'd4;
      endcase
      return r;
   endfunction

   task automatic check_outputs(input string tag);
      checks++;
      assert (i_inst_addr === exp_pc) else begin
         failures++;
         $error("FAIL %s i_inst_addr got %h expected %h", tag, i_inst_addr, exp_pc);
      end
      checks++;
      assert (PC_F === exp_pc) else begin
         failures++;
         $error("FAIL %s PC_F got %h expected %h", tag, PC_F, exp_pc);
      end
      checks++;
      assert (PC4_F === exp_pc + 32'd4) else begin
         failures++;
         $error("FAIL %s PC4_F got %h expected %h", tag, PC4_F, exp_pc + 32'd4);
      end
      checks++;
      assert (misalign_F === (exp_pc[1:0] != 2'b00)) else begin
         failures++;
         $error("FAIL %s misalign_F got %b expected %b", tag, misalign_F, exp_pc[1:0] != 2'b00);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge.
   task automatic step(input logic rst, input logic st, input logic bz, input logic sr,
                       input logic [1:0] sel, input logic tk, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs, input logic [31:0] pc4d,
                       input string tag);
      @(negedge clk);
      reset = rst; stall = st; BUSY = bz; start = sr;
      npc_sel_D = sel; br_taken_D = tk; imm16_D = i16; imm26_D = i26;
      rs_data_D = rs; PC4_D = pc4d;
      #1;
      // Freeze inputs must not reach the outputs combinationally.
      if (!rst) check_outputs({tag, "_pre"});
      if (rst) exp_pc = 32'h0000_3000;
      else if (!(st | bz | sr)) exp_pc = ref_npc(exp_pc, sel, tk, i16, i26, rs, pc4d);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic jr_to(input logic [31:0] target, input string tag);
      step(0, 0, 0, 0, 2'd3, 0, 16'h0, 26'h0, target, 32'h0, tag);
   endtask

   initial begin
      // Reset and free-running fetch.
      step(1, 0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 32'h0, "reset");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 32'h0, "seq");
      step(1, 0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 32'h0, "rereset");

      // Branch taken / not taken from PC_F = 0x3010.
      jr_to(32'h0000_3010, "jr3010");
      step(0, 0, 0, 0, 2'd1, 1, 16'hFFFD, 26'h0, 32'h0, 32'h0000_300C, "br_taken");
      jr_to(32'h0000_3010, "jr3010b");
      step(0, 0, 0, 0, 2'd1, 0, 16'hFFFD, 26'h0, 32'h0, 32'h0000_300C, "br_nt");

      // j and jr.
      step(0, 0, 0, 0, 2'd2, 1, 16'h0, 26'h0000C10, 32'h0, 32'h0000_3020, "j");
      step(0, 0, 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h0000_3100, 32'h0, "jr");

      // Freeze sources each held two cycles with a taken branch waiting in D.
      for (int s = 0; s < 3; s++) begin
         jr_to(32'h0000_3008, "jr3008");
         for (int c = 0; c < 2; c++)
            step(0, s == 0, s == 1, s == 2, 2'd1, 1, 16'h0004, 26'h0, 32'h0, 32'h0000_3008,
                 "frozen");
         step(0, 0, 0, 0, 2'd1, 1, 16'h0004, 26'h0, 32'h0, 32'h0000_3008, "release");
      end

      // Reset beats stall and BUSY.
      step(1, 1, 1, 0, 2'd3, 0, 16'h0, 26'h0, 32'h1234_5678, 32'h0, "reset_stall");

      // Wrap and misaligned jr.
      jr_to(32'hFFFF_FFFC, "jr_top");
      step(0, 0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 32'h0, "wrap");
      jr_to(32'h0000_3002, "jr_misalign");
      // br_taken ignored outside NPC_BR.
      step(0, 0, 0, 0, 2'd0, 1, 16'h8000, 26'h0, 32'h0, 32'h0, "tk_ignored");

      // Randomized traffic against the model.
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
              26'($urandom), $urandom, $urandom, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
